// File: rtl/sram_pkg.sv
// Shared definitions for the parametrised 1RW SRAM model.
//   sram_state_e  : init engine state (INIT / READY)
//   SRAM_MAX_W    : upper bound on word width handled by expand_mask
//   expand_mask() : widens a per-group write mask to a per-bit enable
//   cfg_ok()      : geometry sanity check used at elaboration
package sram_pkg;

  typedef enum logic [0:0] {
    SRAM_INIT  = 1'b0,
    SRAM_READY = 1'b1
  } sram_state_e;

  localparam int unsigned SRAM_MAX_W  = 256;
  localparam int unsigned SRAM_MAX_IW = 8;

  // Bit b of the result is mask[b / (data_w / mask_w)]; bits at or above
  // data_w are left at zero.
  function automatic logic [SRAM_MAX_W-1:0] expand_mask(
    input logic [SRAM_MAX_W-1:0] mask,
    input int unsigned           data_w,
    input int unsigned           mask_w
  );
    logic [SRAM_MAX_W-1:0] bit_en;
    int unsigned           grp;
    bit_en = '0;
    grp    = data_w / mask_w;
    for (int unsigned b = 0; b < SRAM_MAX_W; b++) begin
      if (b < data_w) begin
        bit_en[SRAM_MAX_IW'(b)] = mask[SRAM_MAX_IW'(b / grp)];
      end
    end
    return bit_en;
  endfunction

  function automatic bit cfg_ok(
    input int unsigned addr_w,
    input int unsigned data_w,
    input int unsigned mask_w
  );
    return (addr_w >= 1) && (mask_w >= 1) && (mask_w <= data_w) &&
           ((data_w % mask_w) == 0) && (data_w < SRAM_MAX_W);
  endfunction

endpackage

// File: rtl/sram_init_fsm.sv
// Init engine for sram_1rw_init_ext.
// After reset (or a clear request while ready) it walks every address once,
// asserting init_we_o, then reports ready.
//   clk_i       : clock, rising edge
//   rst_ni      : asynchronous active-low reset
//   clear_i     : re-init request, honoured only while ready
//   init_we_o   : write INIT_VAL to init_addr_o this cycle
//   init_addr_o : entry being initialised
//   ready_o     : array initialised (registered)
module sram_init_fsm
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  output logic              init_we_o,
  output logic [ADDR_W-1:0] init_addr_o,
  output logic              ready_o
);

  sram_state_e       state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      SRAM_INIT: begin
        cnt_d = cnt_q + 1'b1;
        // Last entry written this cycle; counter wraps back to zero.
        if (cnt_q == '1) begin
          state_d = SRAM_READY;
        end
      end
      SRAM_READY: begin
        if (clear_i) begin
          state_d = SRAM_INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = SRAM_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SRAM_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign init_we_o   = (state_q == SRAM_INIT);
  assign init_addr_o = cnt_q;
  assign ready_o     = (state_q == SRAM_READY);

endmodule

// File: rtl/sram_1rw_init_ext.sv
// Parametrised single-port (1RW) SRAM behavioural model with masked writes,
// read-valid strobe, held read data, optional output register and a
// hardware init engine.
//   RW0_clk    : clock, rising edge
//   RW0_rst_n  : asynchronous active-low reset
//   RW0_addr   : access address
//   RW0_en     : access enable
//   RW0_wmode  : 1 = write, 0 = read
//   RW0_wmask  : per-group write enable (DATA_W/MASK_W bits per group)
//   RW0_wdata  : write data
//   RW0_clear  : single-cycle re-init request
//   RW0_ready  : array initialised, accesses accepted
//   RW0_rvalid : RW0_rdata carries new read data this cycle
//   RW0_rdata  : read data, held between reads
module sram_1rw_init_ext
  import sram_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 10,
  parameter int unsigned       DATA_W   = 20,
  parameter int unsigned       MASK_W   = 10,
  parameter bit                OUT_REG  = 1'b0,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              RW0_clk,
  input  logic              RW0_rst_n,
  input  logic [ADDR_W-1:0] RW0_addr,
  input  logic              RW0_en,
  input  logic              RW0_wmode,
  input  logic [MASK_W-1:0] RW0_wmask,
  input  logic [DATA_W-1:0] RW0_wdata,
  input  logic              RW0_clear,
  output logic              RW0_ready,
  output logic              RW0_rvalid,
  output logic [DATA_W-1:0] RW0_rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  if (!cfg_ok(ADDR_W, DATA_W, MASK_W)) begin : g_cfg_err
    $error("sram_1rw_init_ext: unsupported ADDR_W/DATA_W/MASK_W combination");
  end

  logic              init_we;
  logic [ADDR_W-1:0] init_addr;
  logic              ready;

  sram_init_fsm #(
    .ADDR_W(ADDR_W)
  ) u_init_fsm (
    .clk_i      (RW0_clk),
    .rst_ni     (RW0_rst_n),
    .clear_i    (RW0_clear),
    .init_we_o  (init_we),
    .init_addr_o(init_addr),
    .ready_o    (ready)
  );

  // Clear takes priority over a simultaneous access.
  logic accept, rd_acc, wr_acc;
  assign accept = RW0_en & ready & ~RW0_clear;
  assign rd_acc = accept & ~RW0_wmode;
  assign wr_acc = accept &  RW0_wmode;

  logic [SRAM_MAX_W-1:0]      bit_en_full;
  logic [DATA_W-1:0]          bit_en;
  logic [SRAM_MAX_W-1:DATA_W] unused_bit_en;
  assign bit_en_full   = expand_mask(SRAM_MAX_W'(RW0_wmask), DATA_W, MASK_W);
  assign bit_en        = bit_en_full[DATA_W-1:0];
  assign unused_bit_en = bit_en_full[SRAM_MAX_W-1:DATA_W];

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // init_we and wr_acc are mutually exclusive (wr_acc needs ready).
  always_comb begin
    mem_we    = init_we | wr_acc;
    mem_waddr = RW0_addr;
    mem_wdata = (mem_q[RW0_addr] & ~bit_en) | (RW0_wdata & bit_en);
    if (init_we) begin
      mem_waddr = init_addr;
      mem_wdata = INIT_VAL;
    end
  end

  always_ff @(posedge RW0_clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Address is registered on accept; the array is sampled into rdata_q one
  // edge later, before any write at that edge lands.
  logic              rd_q;
  logic [ADDR_W-1:0] raddr_q;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
    if (!RW0_rst_n) begin
      rd_q     <= 1'b0;
      raddr_q  <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rd_q     <= rd_acc;
      rvalid_q <= rd_q;
      if (rd_acc) begin
        raddr_q <= RW0_addr;
      end
      if (rd_q) begin
        rdata_q <= mem_q[raddr_q];
      end
    end
  end

  if (OUT_REG) begin : g_out_reg
    logic              out_vld_q;
    logic [DATA_W-1:0] out_data_q;

    always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
      if (!RW0_rst_n) begin
        out_vld_q  <= 1'b0;
        out_data_q <= '0;
      end else begin
        out_vld_q <= rvalid_q;
        if (rvalid_q) begin
          out_data_q <= rdata_q;
        end
      end
    end

    assign RW0_rvalid = out_vld_q;
    assign RW0_rdata  = out_data_q;
  end else begin : g_no_out_reg
    assign RW0_rvalid = rvalid_q;
    assign RW0_rdata  = rdata_q;
  end

  assign RW0_ready = ready;

endmodule

// File: tb/tb_sram_1rw_init_ext.sv
// Self-checking bench for sram_1rw_init_ext.
// u_dut0: ADDR_W=10, DATA_W=20, MASK_W=10, OUT_REG=0, INIT_VAL=0xABCDE,
//         checked every cycle against a transaction-level reference model.
// u_dut1: ADDR_W=4, DATA_W=32, MASK_W=4, OUT_REG=1, INIT_VAL=0,
//         checked with directed back-to-back reads.
module tb_sram_1rw_init_ext;

  localparam logic [19:0] IV0 = 20'hABCDE;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0_n, en0, wm0, clr0;
  logic [9:0]  addr0, mask0;
  logic [19:0] wd0;
  logic        rdy0, vld0;
  logic [19:0] rd0;

  logic        rst1_n, en1, wm1, clr1;
  logic [3:0]  addr1, mask1;
  logic [31:0] wd1;
  logic        rdy1, vld1;
  logic [31:0] rd1;

  sram_1rw_init_ext #(
    .ADDR_W(10), .DATA_W(20), .MASK_W(10), .OUT_REG(1'b0), .INIT_VAL(IV0)
  ) u_dut0 (
    .RW0_clk(clk), .RW0_rst_n(rst0_n), .RW0_addr(addr0), .RW0_en(en0),
    .RW0_wmode(wm0), .RW0_wmask(mask0), .RW0_wdata(wd0), .RW0_clear(clr0),
    .RW0_ready(rdy0), .RW0_rvalid(vld0), .RW0_rdata(rd0)
  );

  sram_1rw_init_ext #(
    .ADDR_W(4), .DATA_W(32), .MASK_W(4), .OUT_REG(1'b1), .INIT_VAL(32'h0)
  ) u_dut1 (
    .RW0_clk(clk), .RW0_rst_n(rst1_n), .RW0_addr(addr1), .RW0_en(en1),
    .RW0_wmode(wm1), .RW0_wmask(mask1), .RW0_wdata(wd1), .RW0_clear(clr1),
    .RW0_ready(rdy1), .RW0_rvalid(vld1), .RW0_rdata(rd1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model for u_dut0: array contents, init entries still to be
  // written, and a read snapshot taken at the moment the read is accepted.
  logic [19:0] mm [1024];
  int          m_left;
  bit          m_ready;
  bit          m_pend;
  logic [19:0] m_pend_d;
  bit          m_vld;
  logic [19:0] m_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_left   = 1024;
    m_ready  = 1'b0;
    m_pend   = 1'b0;
    m_vld    = 1'b0;
    m_rd     = '0;
  endtask

  // One clock of u_dut0: drive, advance the model across the edge, compare.
  task automatic cyc0(input logic en, input logic wm, input logic [9:0] a,
                      input logic [9:0] m, input logic [19:0] d, input logic clr);
    logic        acc;
    logic [19:0] w;
    en0 = en; wm0 = wm; addr0 = a; mask0 = m; wd0 = d; clr0 = clr;
    @(posedge clk);
    m_vld = m_pend;
    if (m_pend) m_rd = m_pend_d;
    m_pend = 1'b0;
    acc = en && m_ready && !clr;
    if (m_left > 0) begin
      mm[1024 - m_left] = IV0;
      m_left--;
      if (m_left == 0) m_ready = 1'b1;
    end else if (clr) begin
      m_left  = 1024;
      m_ready = 1'b0;
    end
    if (acc && wm) begin
      w = mm[a];
      for (int g = 0; g < 10; g++) if (m[g]) w[2*g +: 2] = d[2*g +: 2];
      mm[a] = w;
    end
    if (acc && !wm) begin
      m_pend   = 1'b1;
      m_pend_d = mm[a];
    end
    #1;
    chk("ready0",  {31'd0, rdy0}, {31'd0, m_ready});
    chk("rvalid0", {31'd0, vld0}, {31'd0, m_vld});
    chk("rdata0",  {12'd0, rd0},  {12'd0, m_rd});
  endtask

  task automatic idle0(input int n);
    for (int i = 0; i < n; i++) cyc0(1'b0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic step1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned r;
    en0 = 0; wm0 = 0; addr0 = '0; mask0 = '0; wd0 = '0; clr0 = 0;
    en1 = 0; wm1 = 0; addr1 = '0; mask1 = '0; wd1 = '0; clr1 = 0;
    rst0_n = 1; rst1_n = 1;
    #1; rst0_n = 0; rst1_n = 0;
    #2;
    model_reset();
    chk("rst_ready0",  {31'd0, rdy0}, 32'd0);
    chk("rst_rvalid0", {31'd0, vld0}, 32'd0);
    chk("rst_rdata0",  {12'd0, rd0},  32'd0);
    chk("rst_rvalid1", {31'd0, vld1}, 32'd0);
    chk("rst_rdata1",  rd1,           32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst0_n = 1; rst1_n = 1;

    // Writes presented during INIT are dropped; ready rises after 1024 edges.
    for (int i = 0; i < 1024; i++) begin
      r = $urandom;
      cyc0(1'b1, r[0], 10'(r[11:8]), 10'h3FF, 20'($urandom), 1'b0);
    end
    chk("ready_after_init", {31'd0, rdy0}, 32'd1);
    for (int a = 0; a < 16; a++) cyc0(1'b1, 1'b0, 10'(a), '0, '0, 1'b0);
    idle0(1);
    chk("init_drop", {12'd0, rd0}, {12'd0, IV0});

    // Top entry, one-cycle read latency.
    cyc0(1'b1, 1'b0, 10'h3FF, '0, '0, 1'b0);
    chk("rd3ff_lat_lo", {31'd0, vld0}, 32'd0);
    idle0(1);
    chk("rd3ff_vld",  {31'd0, vld0}, 32'd1);
    chk("rd3ff_data", {12'd0, rd0},  {12'd0, IV0});

    // Masked write, then held data for 5 idle cycles.
    cyc0(1'b1, 1'b1, 10'h005, 10'h3FF, 20'hFFFFF, 1'b0);
    cyc0(1'b1, 1'b1, 10'h005, 10'h001, 20'h00000, 1'b0);
    cyc0(1'b1, 1'b0, 10'h005, '0, '0, 1'b0);
    idle0(1);
    chk("mask_data", {12'd0, rd0}, 32'h000FFFFC);
    for (int i = 0; i < 5; i++) begin
      idle0(1);
      chk("hold_vld",  {31'd0, vld0}, 32'd0);
      chk("hold_data", {12'd0, rd0},  32'h000FFFFC);
    end

    // Read then write same address: old data. Write then read: new data.
    cyc0(1'b1, 1'b0, 10'h005, '0, '0, 1'b0);
    cyc0(1'b1, 1'b1, 10'h005, 10'h3FF, 20'h12345, 1'b0);
    chk("rd_before_wr", {12'd0, rd0}, 32'h000FFFFC);
    cyc0(1'b1, 1'b0, 10'h005, '0, '0, 1'b0);
    idle0(1);
    chk("wr_then_rd", {12'd0, rd0}, 32'h00012345);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      r = $urandom;
      cyc0(r[0] | r[1], r[2], 10'(r[12:8]), 10'($urandom), 20'($urandom), 1'b0);
    end

    // Clear with a simultaneous write; in-flight read still completes.
    cyc0(1'b1, 1'b1, 10'h010, 10'h3FF, 20'h0F0F0, 1'b0);
    cyc0(1'b1, 1'b0, 10'h010, '0, '0, 1'b0);
    cyc0(1'b1, 1'b1, 10'h010, 10'h3FF, 20'h55555, 1'b1);
    chk("clr_ready",   {31'd0, rdy0}, 32'd0);
    chk("clr_inflight", {12'd0, rd0}, 32'h000F0F0);
    for (int i = 0; i < 1024; i++) begin
      r = $urandom;
      cyc0(r[0], r[1], 10'(r[13:8]), 10'h3FF, 20'($urandom), r[2]);
    end
    chk("clr_ready_back", {31'd0, rdy0}, 32'd1);
    cyc0(1'b1, 1'b0, 10'h010, '0, '0, 1'b0);
    idle0(1);
    chk("clr_reinit", {12'd0, rd0}, {12'd0, IV0});

    // Reset at init count 500; outputs clear asynchronously.
    cyc0(1'b0, 1'b0, '0, '0, '0, 1'b1);
    idle0(500);
    #2; rst0_n = 0; #1;
    chk("arst_ready",  {31'd0, rdy0}, 32'd0);
    chk("arst_rvalid", {31'd0, vld0}, 32'd0);
    chk("arst_rdata",  {12'd0, rd0},  32'd0);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst0_n = 1;
    idle0(1024);
    chk("arst_ready_back", {31'd0, rdy0}, 32'd1);
    cyc0(1'b1, 1'b0, 10'h1F4, '0, '0, 1'b0);
    idle0(1);
    chk("arst_reinit", {12'd0, rd0}, {12'd0, IV0});

    // u_dut1: OUT_REG=1, back-to-back reads, two-cycle latency.
    chk("ready1", {31'd0, rdy1}, 32'd1);
    en1 = 1; wm1 = 1; mask1 = 4'hF;
    addr1 = 4'd1; wd1 = 32'h11111111; step1();
    addr1 = 4'd2; wd1 = 32'h22222222; step1();
    addr1 = 4'd3; wd1 = 32'h33333333; step1();
    wm1 = 0;
    addr1 = 4'd1; step1();
    chk("b2b_n0", {31'd0, vld1}, 32'd0);
    addr1 = 4'd2; step1();
    chk("b2b_n1", {31'd0, vld1}, 32'd0);
    addr1 = 4'd3; step1();
    chk("b2b_v1", {31'd0, vld1}, 32'd1);
    chk("b2b_d1", rd1, 32'h11111111);
    en1 = 0; step1();
    chk("b2b_v2", {31'd0, vld1}, 32'd1);
    chk("b2b_d2", rd1, 32'h22222222);
    step1();
    chk("b2b_v3", {31'd0, vld1}, 32'd1);
    chk("b2b_d3", rd1, 32'h33333333);
    step1();
    chk("b2b_end_v", {31'd0, vld1}, 32'd0);
    chk("b2b_end_d", rd1, 32'h33333333);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
